// File: rtl/f2x_share_arbiter_if.sv
// f2x_share_arbiter_if
//   Bundles the requester-side and result-side handshakes of the shared
//   float-to-fixed converter.
//   req_valid/req_ready/req_data : one valid/ready/float slot per requester;
//                                  float for requester i is req_data[i]
//                                  (the same bits as a flat 32*NUM_REQ bus).
//   out_valid/out_ready          : single result handshake.
//   out_data/out_id/out_sat      : fixed-point result, issuing requester,
//                                  and the flag that the result was clamped.
//   master : the requesters and the downstream consumer.
//   slave  : the converter.
interface f2x_share_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2,
   parameter int TOTAL_BITS = 32
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0][31:0] req_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [TOTAL_BITS-1:0]    out_data;
   logic [ID_W-1:0]          out_id;
   logic                     out_sat;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_sat
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, out_sat
   );
endinterface

// File: rtl/f2x_share_arbiter.sv
// f2x_share_arbiter
//   Round-robin shares one IEEE-754 single -> signed Q(TOTAL_BITS-FRACTIONAL_BITS).
//   FRACTIONAL_BITS converter among NUM_REQ requesters. One float is granted
//   per cycle into stage A (capture); stage B converts with saturation and
//   registers the result with the requester id.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : requester and result handshakes (slave side)
//   sat_clr   : synchronous clear of sat_count (wins over an increment)
//   sat_count : number of clamped results delivered, sticks at 0xFFFF
//   busy      : a float is held in stage A or a result is pending
module f2x_share_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int ID_W            = 2,
   parameter int TOTAL_BITS      = 32,
   parameter int FRACTIONAL_BITS = 20
) (
   input  logic                clk,
   input  logic                rst_n,
   f2x_share_arbiter_if.slave  bus,
   input  logic                sat_clr,
   output logic [15:0]         sat_count,
   output logic                busy
);

   // Magnitude width: a 24-bit mantissa shifted left by up to TOTAL_BITS
   // plus one spare bit, so the range compare below never sees a wrap.
   localparam int MW = 24 + TOTAL_BITS + 1;
   localparam logic [MW-1:0] MAG_LIM =
      {{(MW-TOTAL_BITS){1'b0}}, 1'b1, {(TOTAL_BITS-1){1'b0}}};   // 2^(TB-1)
   localparam logic [MW-1:0] MAG_MAX = MAG_LIM - MW'(1);
   localparam logic [TOTAL_BITS-1:0] VAL_MAX = {1'b0, {(TOTAL_BITS-1){1'b1}}};
   localparam logic [TOTAL_BITS-1:0] VAL_MIN = {1'b1, {(TOTAL_BITS-1){1'b0}}};

   logic                  adv_a, adv_b;
   logic                  a_valid;
   logic [31:0]           a_float;
   logic [ID_W-1:0]       a_id;
   logic [ID_W-1:0]       rr_ptr;

   logic                  grant_ok;
   logic [ID_W-1:0]       grant;
   logic [NUM_REQ-1:0]    rdy;
   int                    arb_idx;

   logic                  cv_sign;
   logic [7:0]            cv_exp;
   logic [23:0]           cv_man;
   int                    cv_shift;
   logic [MW-1:0]         cv_mag;
   logic                  cv_ovf;
   logic [TOTAL_BITS-1:0] cv_data;
   logic                  cv_sat;

   assign adv_b = !bus.out_valid | bus.out_ready;
   assign adv_a = !a_valid | adv_b;
   assign busy  = a_valid | bus.out_valid;

   // Round-robin search starting just past the last granted requester.
   always_comb begin
      grant_ok = 1'b0;
      grant    = '0;
      arb_idx  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         arb_idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_ok && bus.req_valid[arb_idx]) begin
            grant_ok = 1'b1;
            grant    = ID_W'(arb_idx);
         end
      end
      rdy = '0;
      for (int i = 0; i < NUM_REQ; i++)
         rdy[i] = rst_n & adv_a & grant_ok & (grant == ID_W'(i));
   end

   assign bus.req_ready = rdy;

   // Stage A: capture the granted float. rr_ptr only moves on a handshake,
   // so an idle cycle does not skip anyone's turn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         a_float <= '0;
         a_id    <= '0;
         rr_ptr  <= ID_W'(NUM_REQ - 1);
      end else if (adv_a) begin
         a_valid <= grant_ok;
         if (grant_ok) begin
            a_float <= bus.req_data[grant];
            a_id    <= grant;
            rr_ptr  <= grant;
         end
      end
   end

   // Float -> fixed. Value = man * 2^(exp-150), scaled by 2^FRACTIONAL_BITS.
   // Any left shift beyond TOTAL_BITS is already far out of range, so it is
   // flagged directly rather than shifted.
   always_comb begin
      cv_sign  = a_float[31];
      cv_exp   = a_float[30:23];
      cv_man   = {1'b1, a_float[22:0]};
      cv_shift = int'(cv_exp) - 150 + FRACTIONAL_BITS;
      cv_mag   = '0;
      cv_ovf   = 1'b0;
      cv_data  = '0;
      cv_sat   = 1'b0;
      if (cv_shift > TOTAL_BITS)
         cv_ovf = 1'b1;
      else if (cv_shift >= 0)
         cv_mag = MW'(cv_man) << cv_shift;
      else if (cv_shift > -24)
         cv_mag = MW'(cv_man >> (-cv_shift));

      if (cv_exp == 8'd0) begin
         cv_data = '0;
      end else if (cv_exp == 8'hFF || cv_ovf ||
                   (!cv_sign && cv_mag > MAG_MAX) ||
                   ( cv_sign && cv_mag > MAG_LIM)) begin
         cv_sat  = 1'b1;
         cv_data = cv_sign ? VAL_MIN : VAL_MAX;
      end else begin
         // Negating exactly 2^(TB-1) lands on VAL_MIN, which is representable.
         cv_data = cv_sign ? -cv_mag[TOTAL_BITS-1:0] : cv_mag[TOTAL_BITS-1:0];
      end
   end

   // Stage B: result register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_id    <= '0;
         bus.out_sat   <= 1'b0;
      end else if (adv_b) begin
         bus.out_valid <= a_valid;
         if (a_valid) begin
            bus.out_data <= cv_data;
            bus.out_id   <= a_id;
            bus.out_sat  <= cv_sat;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_count <= '0;
      else if (sat_clr)
         sat_count <= '0;
      else if (bus.out_valid && bus.out_ready && bus.out_sat && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end

endmodule

// File: doc/f2x_share_arbiter.md
Name: f2x_share_arbiter

Overview:
- Shares one float-to-fixed conversion datapath (IEEE-754 single to signed Q format) among NUM_REQ requesters.
- Each requester has its own valid/ready port. A round-robin arbiter grants one float per cycle into a 2-stage pipeline.
- Stage A captures the float; stage B converts with saturation and registers the result, tagged with the requester id, behind a single output valid/ready port.
- Sits between the reconstruction front-ends and the fixed-point recon core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must be >= clog2(NUM_REQ).
- TOTAL_BITS, 32, fixed-point output width.
- FRACTIONAL_BITS, 20, fractional bits of the output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready, at most one bit high.
- req_data  in  32*NUM_REQ  float for requester i is in bits [32*i+31:32*i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  TOTAL_BITS  signed fixed-point result.
- out_id  out  ID_W  index of the requester that issued this result.
- out_sat  out  1  result was clamped.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  16  count of saturated results, saturating at 0xFFFF.
- busy  out  1  a_valid | out_valid.

Behaviour:
- Reset (async assert, sync release): a_valid=0, out_valid=0, out_data=0, out_id=0, out_sat=0, sat_count=0, rr_ptr=NUM_REQ-1. req_ready is 0 while rst_n=0.
- Flow control:
  - adv_b = !out_valid | out_ready.
  - adv_a = !a_valid | adv_b.
- Arbitration (combinational):
  - Search from (rr_ptr+1) mod NUM_REQ upward with wrap. The first i with req_valid[i]=1 is the grant g.
  - req_ready[i] = adv_a & (i==g). With no requests, all req_ready=0.
  - req_ready may depend on req_valid. Requesters must not make valid depend on ready.
- Stage A, on adv_a:
  - a_valid <= any req_valid.
  - a_float <= req_data[g].
  - a_id <= g.
  - rr_ptr <= g only on a handshake; rr_ptr is unchanged when idle.
- Stage B, on adv_b:
  - out_valid <= a_valid; out_data/out_id/out_sat are loaded from the stage A conversion.
  - Output registers are held while out_valid & !out_ready.
- Latency and throughput:
  - Handshake at edge t gives out_valid at edge t+1, i.e. result visible 2 cycles after valid is presented.
  - Throughput is 1 result per cycle when out_ready=1.
- Conversion (signed Q(TOTAL_BITS-FRACTIONAL_BITS).FRACTIONAL_BITS):
  - Fields: s=f[31], e=f[30:23], m={1,f[22:0]}.
  - e==0 (zero/subnormal): result 0, sat 0.
  - e==255 (Inf/NaN): sat 1, result MAX if s=0, MIN if s=1.
  - Otherwise mag = m shifted by (e-127+FRACTIONAL_BITS-23). Negative shift is a right shift that truncates toward zero; shifts beyond 24 bits give 0.
  - If mag > MAX (positive) or mag > 2^(TOTAL_BITS-1) (negative): clamp, sat=1.
  - Else result = s ? -mag : mag.
  - MAX = 2^(TOTAL_BITS-1)-1; MIN = -2^(TOTAL_BITS-1). -mag of exactly 2^(TOTAL_BITS-1) is MIN with sat=0.
  - Internal shift width must cover 24+TOTAL_BITS bits with no silent wrap.
- sat_count:
  - Increments when out_valid & out_ready & out_sat; saturates at 0xFFFF.
  - sat_clr has priority over an increment in the same cycle, giving 0.
- Reset mid-operation: pipeline contents are discarded and no partial result is emitted.

Test Plan:
- Single requester 0 sends 0x3F800000 (1.0), out_ready=1 -> 2 cycles later out_valid=1, out_data=0x00100000, out_id=0, out_sat=0.
- Values:
  - 0xC0200000 (-2.5) -> 0xFFD80000.
  - 0x3F000000 -> 0x00080000.
  - 0x00000000 and 0x00400000 (subnormal) -> 0.
  - 0x33800000 (2^-24) -> 0.
- Saturation:
  - 0x45800000 (4096.0) -> 0x7FFFFFFF, sat=1.
  - 0xC5800000 -> 0x80000000, sat=1.
  - 0xC5000000 (-2048.0) -> 0x80000000, sat=0.
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, sat=1.
  - sat_count = 3 after these; sat_clr -> 0.
- NUM_REQ=4, all req_valid held high, out_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; out_id follows the same order 2 cycles later. With only 1 and 3 valid -> grants alternate 1,3,1.
- out_ready low for 3 cycles with a full pipeline -> out_data/out_id stable, all req_ready=0. On release, results drain in order with no loss or duplication.
- rst_n pulsed low while both stages are valid -> out_valid=0 immediately (asynchronously); after release, the first grant goes to requester 0; sat_count=0.
